// File: rtl/poly_uniform_eta_sampler.sv
// rtl/poly_uniform_eta_sampler.sv - rejection sampler for one [-ETA,ETA] polynomial
// Optional rej_cnt output enabled by `define POLY_ETA_REJCNT_EN.
module poly_uniform_eta_sampler #(
   parameter int ETA = 2,
   parameter int N   = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_coeff,
   output logic [7:0]  out_idx,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
`ifdef POLY_ETA_REJCNT_EN
   output logic [15:0] rej_cnt,
`endif
   output logic        done
);

   generate
      if (ETA != 2 && ETA != 4) begin : g_bad_eta
         $error("poly_uniform_eta_sampler: ETA must be 2 or 4");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, FETCH, EMIT_LO, EMIT_HI, DONE} state_t;

   state_t            state, state_nx;
   logic [8:0]        count;
   logic [7:0]        byte_q;
   logic [3:0]        t;
   logic [3:0]        t_mod5;
   logic              accept;
   logic signed [4:0] coeff;
   logic              emit;
   logic              hs;
   logic              last;

   // Nibble evaluation: selects the half of the latched byte for the current emit state
   always_comb begin
      t      = (state == EMIT_HI) ? byte_q[7:4] : byte_q[3:0];
      t_mod5 = t;
      accept = 1'b0;
      coeff  = '0;
      if (t >= 4'd10)
         t_mod5 = t - 4'd10;
      else if (t >= 4'd5)
         t_mod5 = t - 4'd5;
      if (ETA == 2) begin
         accept = (t < 4'd15);
         coeff  = 5'sd2 - $signed({1'b0, t_mod5});
      end else begin
         accept = (t < 4'd9);
         coeff  = 5'sd4 - $signed({1'b0, t});
      end
   end

   assign emit = (state == EMIT_LO) || (state == EMIT_HI);
   assign hs   = emit && accept && out_ready;
   assign last = (count == 9'(N - 1));

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = FETCH;
         FETCH:   if (in_valid) state_nx = EMIT_LO;
         EMIT_LO: begin
            if (!accept)
               state_nx = EMIT_HI;
            else if (out_ready)
               state_nx = last ? DONE : EMIT_HI;
         end
         EMIT_HI: begin
            if (!accept)
               state_nx = FETCH;
            else if (out_ready)
               state_nx = last ? DONE : FETCH;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         byte_q <= '0;
      end else begin
         if (state == IDLE && start)
            count <= '0;
         else if (hs)
            count <= count + 9'd1;
         if (state == FETCH && in_valid)
            byte_q <= in_data;
      end
   end

   always_comb begin
      in_ready  = (state == FETCH);
      out_valid = emit && accept;
      out_coeff = out_valid ? {{27{coeff[4]}}, coeff} : 32'd0;
      out_idx   = out_valid ? count[7:0] : 8'd0;
      busy      = (state == FETCH) || emit;
      done      = (state == DONE);
   end

`ifdef POLY_ETA_REJCNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         rej_cnt <= '0;
      else if (state == IDLE && start)
         rej_cnt <= '0;
      else if (emit && !accept && rej_cnt != 16'hFFFF)
         rej_cnt <= rej_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_poly_uniform_eta_sampler.sv
// tb/tb_poly_uniform_eta_sampler.sv - directed vector bench for poly_uniform_eta_sampler
// Instance a uses ETA=2, instance b uses ETA=4.
module tb_poly_uniform_eta_sampler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  a_in_data, b_in_data;
   logic        a_in_valid, b_in_valid;
   logic        a_in_ready, b_in_ready;
   logic [31:0] a_out_coeff, b_out_coeff;
   logic [7:0]  a_out_idx, b_out_idx;
   logic        a_out_valid, b_out_valid;
   logic        a_out_ready, b_out_ready;
   logic        a_busy, b_busy;
   logic        a_done, b_done;
`ifdef POLY_ETA_REJCNT_EN
   logic [15:0] a_rej_cnt, b_rej_cnt;
`endif

   always #5 clk = ~clk;

   poly_uniform_eta_sampler #(.ETA(2), .N(256)) dut_a (
      .clk(clk), .rst(rst), .start(start),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_coeff(a_out_coeff), .out_idx(a_out_idx), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .busy(a_busy),
`ifdef POLY_ETA_REJCNT_EN
      .rej_cnt(a_rej_cnt),
`endif
      .done(a_done)
   );

   poly_uniform_eta_sampler #(.ETA(4), .N(256)) dut_b (
      .clk(clk), .rst(rst), .start(start),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_coeff(b_out_coeff), .out_idx(b_out_idx), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .busy(b_busy),
`ifdef POLY_ETA_REJCNT_EN
      .rej_cnt(b_rej_cnt),
`endif
      .done(b_done)
   );

   int nchk = 0;
   int nerr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          sel;
      logic [7:0]  b;
      int          n;
      logic [31:0] c0;
      logic [31:0] c1;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs[NV];

   int          got_n;
   logic [31:0] got_c[4];
   logic [7:0]  got_i[4];
   bit          got_done;

   // Pushes one byte into the selected instance and records emitted coefficients until it refetches or finishes
   task automatic feed(input bit sel, input logic [7:0] b);
      int guard;
      got_n    = 0;
      got_done = 0;
      guard    = 0;
      while (!(sel ? b_in_ready : a_in_ready) && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("in_ready_wait", 32'(sel ? b_in_ready : a_in_ready), 32'd1);
      if (sel) begin b_in_data = b; b_in_valid = 1'b1; end
      else     begin a_in_data = b; a_in_valid = 1'b1; end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      guard = 0;
      while (!(sel ? b_in_ready : a_in_ready) && guard < 10) begin
         if (sel ? b_done : a_done) begin
            got_done = 1;
            break;
         end
         if (sel ? (b_out_valid && b_out_ready) : (a_out_valid && a_out_ready)) begin
            if (got_n < 4) begin
               got_c[got_n] = sel ? b_out_coeff : a_out_coeff;
               got_i[got_n] = sel ? b_out_idx : a_out_idx;
            end
            got_n++;
         end
         @(posedge clk); #1;
         guard++;
      end
      check("emit_bound", 32'(guard < 10), 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   int ia, ib, eidx;

   initial begin
      vecs[0]  = '{0, 8'h00, 2,  2,  2};
      vecs[1]  = '{0, 8'hFF, 0,  0,  0};
      vecs[2]  = '{0, 8'h7A, 2,  2,  0};
      vecs[3]  = '{0, 8'h34, 2, -2, -1};
      vecs[4]  = '{0, 8'hE9, 2, -2, -2};
      vecs[5]  = '{0, 8'h5F, 1,  2,  0};
      vecs[6]  = '{0, 8'h86, 2,  1, -1};
      vecs[7]  = '{1, 8'h98, 1, -4,  0};
      vecs[8]  = '{1, 8'h00, 2,  4,  4};
      vecs[9]  = '{1, 8'hF7, 1, -3,  0};
      vecs[10] = '{1, 8'h9A, 0,  0,  0};
      vecs[11] = '{1, 8'h21, 2,  3,  2};

      rst = 1'b1; start = 1'b0;
      a_in_data = '0; b_in_data = '0; a_in_valid = 1'b0; b_in_valid = 1'b0;
      a_out_ready = 1'b1; b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_in_ready",  32'(a_in_ready), 32'd0);
      check("rst_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_out_coeff", a_out_coeff, 32'd0);
      check("rst_out_idx",   32'(a_out_idx), 32'd0);
      check("rst_busy",      32'(a_busy), 32'd0);
      check("rst_done",      32'(a_done), 32'd0);
      check("rst_b_in_ready", 32'(b_in_ready), 32'd0);

      pulse_start();
      check("start_busy",     32'(a_busy), 32'd1);
      check("start_in_ready", 32'(a_in_ready), 32'd1);
      check("start_b_busy",   32'(b_busy), 32'd1);

      ia = 0; ib = 0;
      for (int i = 0; i < NV; i++) begin
         feed(vecs[i].sel, vecs[i].b);
         eidx = vecs[i].sel ? ib : ia;
         check($sformatf("v%0d_n", i), 32'(got_n), 32'(vecs[i].n));
         if (vecs[i].n >= 1) begin
            check($sformatf("v%0d_c0", i), got_c[0], vecs[i].c0);
            check($sformatf("v%0d_i0", i), 32'(got_i[0]), 32'(eidx));
         end
         if (vecs[i].n >= 2) begin
            check($sformatf("v%0d_c1", i), got_c[1], vecs[i].c1);
            check($sformatf("v%0d_i1", i), 32'(got_i[1]), 32'(eidx + 1));
         end
         if (vecs[i].sel) ib += vecs[i].n;
         else             ia += vecs[i].n;
      end

      // Backpressure on instance a: byte 0x34 at idx 11
      a_out_ready = 1'b0;
      a_in_data = 8'h34; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp%0d_valid", k), 32'(a_out_valid), 32'd1);
         check($sformatf("bp%0d_coeff", k), a_out_coeff, 32'hFFFF_FFFE);
         check($sformatf("bp%0d_idx", k), 32'(a_out_idx), 32'(ia));
         check($sformatf("bp%0d_in_ready", k), 32'(a_in_ready), 32'd0);
         @(posedge clk); #1;
      end
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_hi_valid", 32'(a_out_valid), 32'd1);
      check("bp_hi_coeff", a_out_coeff, 32'hFFFF_FFFF);
      check("bp_hi_idx",   32'(a_out_idx), 32'(ia + 1));
      @(posedge clk); #1;
      check("bp_refetch",  32'(a_in_ready), 32'd1);

      // Full polynomial: 0xF1 then 128 zero bytes
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pulse_start();
      feed(0, 8'hF1);
      check("full_first_n", 32'(got_n), 32'd1);
      check("full_first_c", got_c[0], 32'd1);
      check("full_first_i", 32'(got_i[0]), 32'd0);
      for (int k = 0; k < 128; k++) begin
         feed(0, 8'h00);
         if (k < 127) begin
            check($sformatf("full%0d_n", k), 32'(got_n), 32'd2);
            check($sformatf("full%0d_c0", k), got_c[0], 32'd2);
            check($sformatf("full%0d_c1", k), got_c[1], 32'd2);
            check($sformatf("full%0d_i1", k), 32'(got_i[1]), 32'(2 + 2 * k));
            check($sformatf("full%0d_done", k), 32'(got_done), 32'd0);
         end else begin
            check("full_last_n", 32'(got_n), 32'd1);
            check("full_last_c", got_c[0], 32'd2);
            check("full_last_i", 32'(got_i[0]), 32'd255);
            check("full_last_done_seen", 32'(got_done), 32'd1);
         end
      end
      check("done_pulse",  32'(a_done), 32'd1);
      check("done_busy",   32'(a_busy), 32'd0);
      check("done_in_rdy", 32'(a_in_ready), 32'd0);
      a_in_data = 8'h00; a_in_valid = 1'b1;
      @(posedge clk); #1;
      check("after_done",     32'(a_done), 32'd0);
      check("after_in_rdy",   32'(a_in_ready), 32'd0);
      check("after_busy",     32'(a_busy), 32'd0);
      @(posedge clk); #1;
      check("after2_in_rdy",  32'(a_in_ready), 32'd0);
      check("after2_done",    32'(a_done), 32'd0);
      a_in_valid = 1'b0;
`ifdef POLY_ETA_REJCNT_EN
      check("rej_cnt", 32'(a_rej_cnt), 32'd1);
`endif

      // Reset while coefficient 100 is presented
      pulse_start();
      for (int k = 0; k < 50; k++) feed(0, 8'h00);
      a_in_data = 8'h00; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      check("mid_valid", 32'(a_out_valid), 32'd1);
      check("mid_idx",   32'(a_out_idx), 32'd100);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_valid", 32'(a_out_valid), 32'd0);
      check("mid_rst_coeff", a_out_coeff, 32'd0);
      check("mid_rst_idx",   32'(a_out_idx), 32'd0);
      check("mid_rst_busy",  32'(a_busy), 32'd0);
      check("mid_rst_rdy",   32'(a_in_ready), 32'd0);
      check("mid_rst_done",  32'(a_done), 32'd0);
      pulse_start();
      feed(0, 8'h7A);
      check("restart_n",  32'(got_n), 32'd2);
      check("restart_c0", got_c[0], 32'd2);
      check("restart_i0", 32'(got_i[0]), 32'd0);
      check("restart_c1", got_c[1], 32'd0);
      check("restart_i1", 32'(got_i[1]), 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
